// File: rtl/aucohl_sdm_dac_if.sv
`default_nettype none
// ============================================================================
// Module      : aucohl_sdm_dac_if
// Description : Sample stream port (data/valid/ready) feeding the delta-sigma
//               DAC buffer. master = sample producer, slave = DAC.
// Revision    : 1.0 - initial release
// ============================================================================
interface aucohl_sdm_dac_if #(
  parameter int SIZE = 8
) ();
  logic [SIZE-1:0] data_in;
  logic            valid;
  logic            ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/aucohl_sdm_dac.sv
`default_nettype none
// ============================================================================
// Module      : aucohl_sdm_dac
// Description : First-order 1-bit delta-sigma DAC. Samples arrive over a
//               valid/ready port into a 2^AW-deep FIFO and are consumed every
//               clk_div+1 modulator steps. Ones-density of dout = sample/2^SIZE.
//               Optional dither: define AUCOHL_SDM_DAC_DITHER_EN to add a
//               16-bit LFSR bit as carry-in to the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module aucohl_sdm_dac #(
  parameter int SIZE = 8,
  parameter int AW   = 2,
  parameter int W    = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          en,
  input  wire logic          flush,
  input  wire logic [W-1:0]  clk_div,
  aucohl_sdm_dac_if.slave    bus,
  output logic               dout,
  output logic               underrun,
  output logic [AW:0]        level,
  output logic               busy
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [SIZE:0]   acc;
  logic [SIZE-1:0] cur;
  logic [W-1:0]    counter;
  logic [SIZE:0]   sum;
  logic            push, avail, pop, start, step, slot, cin;

  // flush outranks both push and pop; a sample pushed this cycle is not yet
  // counted in level, so it cannot be popped in the same cycle
  assign bus.ready = (level != DEPTH_L);
  assign push      = bus.valid & bus.ready & ~flush;
  assign avail     = (level != '0) & ~flush;
  assign slot      = (counter == '0);
  assign busy      = (state == RUN);

  // the carry out of the accumulator is the bitstream, so dout is a flop output
  assign dout = acc[SIZE];
  assign sum  = {1'b0, acc[SIZE-1:0]} + {1'b0, cur} + {{SIZE{1'b0}}, cin};

`ifdef AUCOHL_SDM_DAC_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign cin     = lfsr[0];

  // dither source: advances only on modulator steps, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr <= 16'hACE1;
    else if (step) lfsr <= {lfsr_fb, lfsr[15:1]};
  end
`else
  assign cin = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (en && avail) begin
          pop       = 1'b1;
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          pop  = slot & avail;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sample storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // modulator datapath: accumulator, current sample, slot counter, underrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cur      <= '0;
      counter  <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= step & slot & ~avail;
      if (pop) cur <= mem[rd_ptr];
      if (step) begin
        acc     <= sum;
        counter <= slot ? clk_div : counter - W'(1);
      end else begin
        acc <= '0;
        if (start) counter <= clk_div;
      end
    end
  end

endmodule
`default_nettype wire
